seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
- Time-multiplexed driver for a 6-digit common-anode seven-segment display.
- Takes the six BCD digits produced by the binary-to-BCD digit splitter and holds them in a tear-free shadow buffer.
- Scans one digit at a time, inserting a dead-time blank between digits to suppress ghosting.
- Supports optional leading-zero blanking.

Parameters:
- SCAN_DIV, 50000: clocks each digit slot lasts (dead phase plus on phase); must be at least 2.
- DEAD_CYC, 500: blanked clocks at the start of each digit slot; 0 <= DEAD_CYC < SCAN_DIV.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous reset, active-low
- dat_1_i..dat_6_i  in  4 each  BCD digits; dat_1_i is units, dat_6_i is hundred-thousands
- load_i  in  1  capture dat_*_i into the pending buffer on this edge
- blank_lz_i  in  1  1 = blank leading zeros
- seg_o  out  8  active-low segments {dp,g,f,e,d,c,b,a}; dp is always 1
- sel_o  out  6  active-low digit select; bit k drives digit k+1
- frame_done_o  out  1  one-cycle pulse at the end of digit-6 slot

Behaviour:
- Reset and interface:
  - One clock. Reset is synchronous and active-low; all state is sampled on posedge clk_i with rst_i=0.
  - Reset values: cnt=0, idx=0, active buffer=0, pending buffer=0, pend=0, seg_o=8'hFF, sel_o=6'h3F, frame_done_o=0.
  - Reset asserted mid-frame aborts the scan. Scanning restarts at digit 1, dead phase, on the first edge with rst_i=1.
- Slot counter:
  - cnt runs 0..SCAN_DIV-1. At cnt=SCAN_DIV-1, cnt wraps to 0 and idx advances 0..5, wrapping from 5 to 0.
  - Frame boundary = the edge where idx wraps from 5 to 0.
- Phase FSM, decoded from cnt:
  - DEAD when cnt < DEAD_CYC.
  - ON otherwise.
  - With DEAD_CYC=0 there is no DEAD phase.
- Outputs:
  - All outputs are registered and lag cnt/idx by exactly 1 clock.
  - DEAD: sel_o=6'h3F, seg_o=8'hFF.
  - ON: sel_o = ~(6'b1 << idx), seg_o = {1'b1, code(digit idx+1)}.
- Segment code (7 bits, gfedcba, active low), shown as the resulting seg_o byte:
  - 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90.
  - Values 10..15 are blank (seg_o=FF, sel still asserted).
- Leading-zero blanking (blank_lz_i=1):
  - Digits 6 down to 2 are blank while they and every higher digit are 0.
  - Digit 1 is always displayed.
  - Blanking is evaluated on the active buffer and blank_lz_i is sampled live.
- Buffering:
  - load_i=1 writes dat_*_i into the pending buffer and sets pend.
  - At a frame boundary with pend=1, active <= pending and pend <= 0.
  - load_i coinciding with a frame boundary writes dat_*_i straight into active as well as pending, and leaves pend=0.
  - Repeated loads within a frame: the last one wins.
  - The active buffer never changes except at a frame boundary.
- frame_done_o:
  - Registered; high for exactly one clock after the frame-boundary edge.
  - Period = 6*SCAN_DIV clocks.
- Width rules:
  - cnt width = clog2(SCAN_DIV).
  - idx is 3 bits; values 6 and 7 are unreachable.
  - No arithmetic overflow paths.

Test Plan:
(all with SCAN_DIV=8, DEAD_CYC=2)
1. Reset: hold rst_i=0 for 3 clocks mid-scan -> seg_o=FF, sel_o=3F, frame_done_o=0 from the first reset edge. After release: 2 clocks blank, then sel_o=3E.
2. Load digits 6..1 = 1,2,3,4,5,6 with blank_lz_i=0, then wait one frame -> each slot: 2 clocks FF/3F, then 6 clocks:
   - digit1: sel 3E, seg 82
   - digit2: sel 3D, seg 92
   - digit3: sel 3B, seg 99
   - digit4: sel 37, seg B0
   - digit5: sel 2F, seg A4
   - digit6: sel 1F, seg F9
   - frame_done_o pulses every 48 clocks.
3. Leading-zero blanking: load 0,0,0,0,4,2 with blank_lz_i=1:
   - digits 6..3 -> seg FF with sel asserted; digit2 -> 99; digit1 -> A4.
   - Load all zeros -> only digit1 shows C0.
   - Set blank_lz_i=0 -> all six digits show C0.
4. Tear-free update: load 9s, then load 1s during digit-3 slot -> digits 4..6 of the current frame still show 90. The next frame shows F9 on every digit.
5. Invalid BCD: load digit1=4'hB, others 0, blank_lz_i=0 -> digit1 slot seg FF with sel 3E; other digits show C0.
6. Simultaneous load at boundary: pulse load_i=8s on the idx 5->0 wrap edge -> digit1 of the new frame shows 80 immediately, and pend stays 0.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// Bus bundle for the six-digit seven-segment scan controller.
// The master side supplies BCD digits and control; the slave side is the
// display driver that returns segment/select lines and the frame strobe.
interface seg7_scan_ctrl_if;
  logic [3:0] dat_1_i;
  logic [3:0] dat_2_i;
  logic [3:0] dat_3_i;
  logic [3:0] dat_4_i;
  logic [3:0] dat_5_i;
  logic [3:0] dat_6_i;
  logic       load_i;
  logic       blank_lz_i;
  logic [7:0] seg_o;
  logic [5:0] sel_o;
  logic       frame_done_o;

  modport master (
    output dat_1_i, dat_2_i, dat_3_i, dat_4_i, dat_5_i, dat_6_i,
    output load_i, blank_lz_i,
    input  seg_o, sel_o, frame_done_o
  );

  modport slave (
    input  dat_1_i, dat_2_i, dat_3_i, dat_4_i, dat_5_i, dat_6_i,
    input  load_i, blank_lz_i,
    output seg_o, sel_o, frame_done_o
  );
endinterface

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed driver for a 6-digit common-anode seven-segment display.
// Digits are captured into a pending buffer and promoted to the active
// buffer only at a frame boundary, so a frame never shows a mix of old and
// new values. Each digit slot starts with a blanked dead phase to suppress
// ghosting. All outputs are registered one clock behind the slot counter.
module seg7_scan_ctrl #(
  parameter int SCAN_DIV = 50000,
  parameter int DEAD_CYC = 500
) (
  input  logic             clk_i,
  input  logic             rst_i,
  seg7_scan_ctrl_if.slave  bus
);

  localparam int              CW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW:0]     DEAD_W   = (CW + 1)'(DEAD_CYC);

  typedef enum logic {
    PH_DEAD = 1'b0,
    PH_ON   = 1'b1
  } phase_t;

  // With no dead time the slot begins directly in the ON phase.
  localparam phase_t PH_START = (DEAD_CYC > 0) ? PH_DEAD : PH_ON;

  // Active-low gfedcba pattern; codes above 9 render as blank.
  function automatic logic [6:0] seg_code(input logic [3:0] d);
    logic [6:0] c;
    case (d)
      4'd0:    c = 7'h40;
      4'd1:    c = 7'h79;
      4'd2:    c = 7'h24;
      4'd3:    c = 7'h30;
      4'd4:    c = 7'h19;
      4'd5:    c = 7'h12;
      4'd6:    c = 7'h02;
      4'd7:    c = 7'h78;
      4'd8:    c = 7'h00;
      4'd9:    c = 7'h10;
      default: c = 7'h7F;
    endcase
    return c;
  endfunction

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nxt_s;
  logic [2:0]    idx_r;
  logic [2:0]    idx_nxt_s;
  phase_t        phase_r;
  phase_t        phase_nxt_s;
  logic          wrap_s;
  logic          boundary_s;
  logic [23:0]   dat_in_s;
  logic [23:0]   act_r;
  logic [23:0]   pbuf_r;
  logic          pend_r;
  logic [3:0]    digit_s;
  logic [5:0]    nz_s;
  logic [7:0]    lz_s;
  logic [7:0]    seg_nxt_s;
  logic [5:0]    sel_nxt_s;
  logic [7:0]    seg_r;
  logic [5:0]    sel_r;
  logic          fd_r;

  assign dat_in_s = {bus.dat_6_i, bus.dat_5_i, bus.dat_4_i,
                     bus.dat_3_i, bus.dat_2_i, bus.dat_1_i};

  assign bus.seg_o        = seg_r;
  assign bus.sel_o        = sel_r;
  assign bus.frame_done_o = fd_r;

  // Slot counter and digit index advance; detects the frame boundary.
  always_comb begin
    wrap_s     = (cnt_r == CNT_LAST);
    boundary_s = wrap_s && (idx_r == 3'd5);
    if (wrap_s) begin
      cnt_nxt_s = {CW{1'b0}};
      if (idx_r == 3'd5) begin
        idx_nxt_s = 3'd0;
      end else begin
        idx_nxt_s = idx_r + 3'd1;
      end
    end else begin
      cnt_nxt_s = cnt_r + CW'(1);
      idx_nxt_s = idx_r;
    end
  end

  // Select the active digit for the current slot and find which digits sit
  // inside an all-zero leading run (digit 1 is never part of that run).
  always_comb begin
    case (idx_r)
      3'd0:    digit_s = act_r[3:0];
      3'd1:    digit_s = act_r[7:4];
      3'd2:    digit_s = act_r[11:8];
      3'd3:    digit_s = act_r[15:12];
      3'd4:    digit_s = act_r[19:16];
      3'd5:    digit_s = act_r[23:20];
      default: digit_s = 4'hF;
    endcase
    for (int i = 0; i < 6; i++) begin
      nz_s[i] = (act_r[i*4 +: 4] != 4'd0);
    end
    lz_s = 8'h00;
    for (int i = 1; i < 6; i++) begin
      lz_s[i] = ~|(nz_s >> i);
    end
  end

  // Phase next-state from the upcoming count, plus output decode for the
  // phase currently held in the register.
  always_comb begin
    phase_nxt_s = PH_ON;
    sel_nxt_s   = 6'h3F;
    seg_nxt_s   = 8'hFF;
    if ({1'b0, cnt_nxt_s} < DEAD_W) begin
      phase_nxt_s = PH_DEAD;
    end else begin
      phase_nxt_s = PH_ON;
    end
    case (phase_r)
      PH_ON: begin
        sel_nxt_s = ~(6'b000001 << idx_r);
        if (bus.blank_lz_i && lz_s[idx_r]) begin
          seg_nxt_s = 8'hFF;
        end else begin
          seg_nxt_s = {1'b1, seg_code(digit_s)};
        end
      end
      default: begin
        sel_nxt_s = 6'h3F;
        seg_nxt_s = 8'hFF;
      end
    endcase
  end

  // Scan state and registered display outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_r   <= {CW{1'b0}};
      idx_r   <= 3'd0;
      phase_r <= PH_START;
      seg_r   <= 8'hFF;
      sel_r   <= 6'h3F;
      fd_r    <= 1'b0;
    end else begin
      cnt_r   <= cnt_nxt_s;
      idx_r   <= idx_nxt_s;
      phase_r <= phase_nxt_s;
      seg_r   <= seg_nxt_s;
      sel_r   <= sel_nxt_s;
      fd_r    <= boundary_s;
    end
  end

  // Pending/active digit buffers; active only changes at a frame boundary,
  // and a load landing on that boundary goes straight to active.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      act_r  <= 24'h000000;
      pbuf_r <= 24'h000000;
      pend_r <= 1'b0;
    end else begin
      if (bus.load_i) begin
        pbuf_r <= dat_in_s;
      end
      if (boundary_s) begin
        if (bus.load_i) begin
          act_r <= dat_in_s;
        end else if (pend_r) begin
          act_r <= pbuf_r;
        end
        pend_r <= 1'b0;
      end else if (bus.load_i) begin
        pend_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl with SCAN_DIV=8, DEAD_CYC=2.
// Expected display words {frame_done, sel, seg} are queued per frame from
// the digits the bench knows are active, then popped against the DUT.
module tb_seg7_scan_ctrl;

  logic clk = 1'b0;
  logic rst;

  seg7_scan_ctrl_if bus();

  seg7_scan_ctrl #(.SCAN_DIV(8), .DEAD_CYC(2)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  logic [14:0] sb_q[$];
  int n_cmp  = 0;
  int n_fail = 0;

  function automatic logic [7:0] seg_ref(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  // Expected output after the c-th edge of a frame (c = 0..47).
  function automatic logic [14:0] exp_at(input int c, input logic [23:0] shown,
                                         input logic blz);
    int          slot;
    int          cc;
    logic        fd;
    logic [5:0]  sel;
    logic [7:0]  seg;
    logic [3:0]  d;
    logic [23:0] upper;
    slot = c / 8;
    cc   = c % 8;
    fd   = (c == 47);
    if (cc < 2) return {fd, 6'h3F, 8'hFF};
    sel   = ~(6'b000001 << slot);
    d     = shown[slot*4 +: 4];
    upper = shown >> (slot * 4);
    if (blz && slot >= 1 && upper == 24'h0) seg = 8'hFF;
    else seg = seg_ref(d);
    return {fd, sel, seg};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_dat(input logic [23:0] v);
    bus.dat_1_i = v[3:0];
    bus.dat_2_i = v[7:4];
    bus.dat_3_i = v[11:8];
    bus.dat_4_i = v[15:12];
    bus.dat_5_i = v[19:16];
    bus.dat_6_i = v[23:20];
  endtask

  task automatic check_one(input string tag);
    logic [14:0] exp_v;
    logic [14:0] obs_v;
    obs_v = {bus.frame_done_o, bus.sel_o, bus.seg_o};
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s scoreboard empty observed=%h", tag, obs_v);
    end else begin
      exp_v = sb_q.pop_front();
      assert (obs_v === exp_v) else begin
        n_fail++;
        $error("FAIL %s observed{fd,sel,seg}=%h expected=%h", tag, obs_v, exp_v);
      end
    end
  endtask

  // One full frame: queue 48 expectations, optionally pulse load at load_cyc.
  task automatic play_frame(input int fr, input logic [23:0] shown,
                            input int load_cyc, input logic [23:0] load_val);
    for (int c = 0; c < 48; c++) sb_q.push_back(exp_at(c, shown, bus.blank_lz_i));
    for (int c = 0; c < 48; c++) begin
      if (c == load_cyc) begin
        set_dat(load_val);
        bus.load_i = 1'b1;
      end
      tick();
      bus.load_i = 1'b0;
      check_one($sformatf("frame%0d_pos%0d", fr, c));
    end
  endtask

  task automatic reset_checks(input string tag);
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back({1'b0, 6'h3F, 8'hFF});
      tick();
      check_one($sformatf("%s_%0d", tag, i));
    end
  endtask

  initial begin
    rst            = 1'b0;
    bus.load_i     = 1'b0;
    bus.blank_lz_i = 1'b0;
    set_dat(24'h000000);
    reset_checks("por_reset");
    rst = 1'b1;
    play_frame(0, 24'h000000, -1, 24'h000000);

    // Abort mid-scan while digit 2 is lit.
    repeat (13) tick();
    rst = 1'b0;
    reset_checks("mid_reset");
    rst = 1'b1;

    play_frame(1, 24'h000000, 10, 24'h123456);
    play_frame(2, 24'h123456, 5, 24'h000042);
    bus.blank_lz_i = 1'b1;
    play_frame(3, 24'h000042, 20, 24'h000000);
    play_frame(4, 24'h000000, -1, 24'h000000);
    bus.blank_lz_i = 1'b0;
    play_frame(5, 24'h000000, 3, 24'h999999);
    // Load during digit-3 slot must not tear the current frame.
    play_frame(6, 24'h999999, 19, 24'h111111);
    play_frame(7, 24'h111111, 30, 24'h00000B);
    // Load on the wrap edge itself must show in the very next frame.
    play_frame(8, 24'h00000B, 47, 24'h888888);
    play_frame(9, 24'h888888, -1, 24'h000000);
    play_frame(10, 24'h888888, -1, 24'h000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
